// File: rtl/adc_responder_pkg.sv
// Shared constants, state types and response byte helpers for the ADC responder.
// Command bytes 0xA1..0xA4 select sample channels 1..4.
package adc_responder_pkg;

  localparam logic [7:0] CMD_BASE = 8'hA0;
  localparam int CHANNEL_MIN = 1;
  localparam int CHANNEL_MAX = 4;
  localparam int DEFAULT_TICKS_PER_CYCLE = 48;
  localparam logic [1:0] HI_MASK = 2'b11;
  localparam int COUNT_W = 16;

  typedef enum logic [2:0] {
    RESP_IDLE,
    RESP_DELAY,
    RESP_SEND_LO,
    RESP_GAP,
    RESP_SEND_HI
  } resp_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  function automatic logic isChannelCommand(input logic [7:0] b);
    return (b >= CMD_BASE + 8'(CHANNEL_MIN)) && (b <= CMD_BASE + 8'(CHANNEL_MAX));
  endfunction

  function automatic logic [7:0] lowByte(input logic [9:0] s);
    return s[7:0];
  endfunction

  function automatic logic [7:0] highByte(input logic [9:0] s);
    return {6'b0, s[9:8] & HI_MASK};
  endfunction

endpackage

// File: rtl/adc_responder_tx.sv
// UART byte serializer: 1 start, 8 data LSB first, 1 stop; idle high.
// ready drops for exactly 10 bit times after an accepted start.
module adc_responder_tx
  import adc_responder_pkg::*;
#(
  parameter int TICKS_PER_CYCLE = DEFAULT_TICKS_PER_CYCLE
) (
  input  logic       clock12MHz,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       ready,
  output logic       serialOut
);

  logic                 active;
  logic [8:0]           shift;
  logic [3:0]           bitsLeft;
  logic [COUNT_W-1:0]   tickCount;

  // serialOut is registered so the line never glitches between bits.
  always_ff @(posedge clock12MHz) begin
    if (reset) begin
      active    <= 1'b0;
      shift     <= '1;
      bitsLeft  <= '0;
      tickCount <= '0;
      serialOut <= 1'b1;
    end else if (!active) begin
      if (start) begin
        active    <= 1'b1;
        serialOut <= 1'b0;
        shift     <= {1'b1, data};
        bitsLeft  <= 4'd9;
        tickCount <= COUNT_W'(TICKS_PER_CYCLE - 1);
      end
    end else if (tickCount != '0) begin
      tickCount <= tickCount - 1'b1;
    end else if (bitsLeft == '0) begin
      active    <= 1'b0;
      serialOut <= 1'b1;
    end else begin
      serialOut <= shift[0];
      shift     <= {1'b1, shift[8:1]};
      bitsLeft  <= bitsLeft - 1'b1;
      tickCount <= COUNT_W'(TICKS_PER_CYCLE - 1);
    end
  end

  assign ready = !active;

endmodule

// File: rtl/adc_responder.sv
// Board-side ADC responder: receives 0xA1..0xA4 over UART, answers with the
// latched 10-bit sample as low byte then high byte.
//   state     | meaning
//   IDLE      | waiting for a channel command
//   DELAY     | counting RESP_DELAY_TICKS before byte 0
//   SEND_LO   | serializing sample[7:0]
//   GAP       | idle line between bytes
//   SEND_HI   | serializing sample[9:8]
module adc_responder
  import adc_responder_pkg::*;
#(
  parameter int TICKS_PER_CYCLE  = DEFAULT_TICKS_PER_CYCLE,
  parameter int RESP_DELAY_TICKS = 48,
  parameter int GAP_TICKS        = 48
) (
  input  logic       clock12MHz,
  input  logic       reset,
  input  logic       serialIn,
  input  logic [9:0] value1,
  input  logic [9:0] value2,
  input  logic [9:0] value3,
  input  logic [9:0] value4,
  output logic       serialOut,
  output logic       busy,
  output logic       badCommand
);

  logic sync1, rxBit;
  rx_state_t rxState, rxStateNext;
  logic [COUNT_W-1:0] rxCount, rxCountNext;
  logic [2:0] rxBitIdx, rxBitIdxNext;
  logic [7:0] rxShift, rxShiftNext;
  resp_state_t state, stateNext;
  logic [COUNT_W-1:0] respCount, respCountNext;
  logic [9:0] respSample, selected;
  logic frameDone, accept, txStart, txReady;
  logic [7:0] txData;

  always_ff @(posedge clock12MHz) begin
    if (reset) begin
      sync1 <= 1'b1;
      rxBit <= 1'b1;
    end else begin
      sync1 <= serialIn;
      rxBit <= sync1;
    end
  end

  always_ff @(posedge clock12MHz) begin
    if (reset) begin
      rxState  <= RX_IDLE;
      rxCount  <= '0;
      rxBitIdx <= '0;
      rxShift  <= '0;
    end else begin
      rxState  <= rxStateNext;
      rxCount  <= rxCountNext;
      rxBitIdx <= rxBitIdxNext;
      rxShift  <= rxShiftNext;
    end
  end

  // Start bit is re-checked half a bit in; later samples land mid-bit.
  always_comb begin
    rxStateNext  = rxState;
    rxCountNext  = rxCount;
    rxBitIdxNext = rxBitIdx;
    rxShiftNext  = rxShift;
    case (rxState)
      RX_IDLE: if (!rxBit) begin
        rxStateNext = RX_START;
        rxCountNext = COUNT_W'(TICKS_PER_CYCLE / 2 - 1);
      end
      RX_START: begin
        if (rxCount != '0) rxCountNext = rxCount - 1'b1;
        else if (rxBit) rxStateNext = RX_IDLE;
        else begin
          rxStateNext  = RX_DATA;
          rxCountNext  = COUNT_W'(TICKS_PER_CYCLE - 1);
          rxBitIdxNext = '0;
        end
      end
      RX_DATA: begin
        if (rxCount != '0) rxCountNext = rxCount - 1'b1;
        else begin
          rxShiftNext = {rxBit, rxShift[7:1]};
          rxCountNext = COUNT_W'(TICKS_PER_CYCLE - 1);
          if (rxBitIdx == 3'd7) rxStateNext = RX_STOP;
          else rxBitIdxNext = rxBitIdx + 1'b1;
        end
      end
      RX_STOP: begin
        if (rxCount != '0) rxCountNext = rxCount - 1'b1;
        else rxStateNext = rxBit ? RX_IDLE : RX_WAIT_HIGH;
      end
      RX_WAIT_HIGH: if (rxBit) rxStateNext = RX_IDLE;
      default: rxStateNext = RX_IDLE;
    endcase
  end

  assign frameDone  = (rxState == RX_STOP) && (rxCount == '0) && rxBit;
  assign badCommand = frameDone && !isChannelCommand(rxShift);
  // busy drops on the first idle cycle after byte 1, so a command landing
  // exactly then is still accepted.
  assign busy   = (state != RESP_IDLE) && !((state == RESP_SEND_HI) && txReady);
  assign accept = frameDone && isChannelCommand(rxShift) && !busy;

  always_comb begin
    case (rxShift[2:0])
      3'd1:    selected = value1;
      3'd2:    selected = value2;
      3'd3:    selected = value3;
      default: selected = value4;
    endcase
  end

  always_ff @(posedge clock12MHz) begin
    if (reset) begin
      state      <= RESP_IDLE;
      respCount  <= '0;
      respSample <= '0;
    end else begin
      state     <= stateNext;
      respCount <= respCountNext;
      if (accept) respSample <= selected;
    end
  end

  // Counters end one cycle early because the serializer registers its start.
  always_comb begin
    stateNext     = state;
    respCountNext = respCount;
    txStart       = 1'b0;
    case (state)
      RESP_IDLE: if (accept) begin
        stateNext     = RESP_DELAY;
        respCountNext = COUNT_W'(RESP_DELAY_TICKS - 1);
      end
      RESP_DELAY: begin
        if (respCount == '0) begin
          txStart   = 1'b1;
          stateNext = RESP_SEND_LO;
        end else respCountNext = respCount - 1'b1;
      end
      RESP_SEND_LO: if (txReady) begin
        if (GAP_TICKS == 1) begin
          txStart   = 1'b1;
          stateNext = RESP_SEND_HI;
        end else begin
          stateNext     = RESP_GAP;
          respCountNext = COUNT_W'(GAP_TICKS - 2);
        end
      end
      RESP_GAP: begin
        if (respCount == '0) begin
          txStart   = 1'b1;
          stateNext = RESP_SEND_HI;
        end else respCountNext = respCount - 1'b1;
      end
      RESP_SEND_HI: if (txReady) begin
        if (accept) begin
          stateNext     = RESP_DELAY;
          respCountNext = COUNT_W'(RESP_DELAY_TICKS - 1);
        end else stateNext = RESP_IDLE;
      end
      default: stateNext = RESP_IDLE;
    endcase
  end

  assign txData = (state == RESP_DELAY) ? lowByte(respSample) : highByte(respSample);

  adc_responder_tx #(
    .TICKS_PER_CYCLE(TICKS_PER_CYCLE)
  ) tx (
    .clock12MHz(clock12MHz),
    .reset     (reset),
    .start     (txStart),
    .data      (txData),
    .ready     (txReady),
    .serialOut (serialOut)
  );

endmodule
